// File: rtl/timer_pkg.sv
// Shared types and constants for the timer command serializer.
// States, frame preamble and frame length used by the top and the bench.
package timer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAP,
        S_SHIFT,
        S_WAIT_DONE,
        S_ACK
    } state_t;

    localparam logic [3:0] PREAMBLE   = 4'b1101;
    localparam int         FRAME_BITS = 8;

    // Full frame as shifted out MSB first: preamble then delay nibble.
    function automatic logic [FRAME_BITS-1:0] frame_of(input logic [3:0] delay);
        return {PREAMBLE, delay};
    endfunction

endpackage

// File: rtl/timer_cmd_serializer_if.sv
// Command handshake bundle between a command source and the serializer.
// master drives commands, slave accepts them.
interface timer_cmd_serializer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_delay;

    modport master (output cmd_valid, output cmd_delay, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_delay, output cmd_ready);
endinterface

// File: rtl/timer_cmd_fifo.sv
// Small command queue (pointer + count), async active-low reset.
// Used only when TIMER_CMD_FIFO_EN is defined.
module timer_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage, pointers and occupancy; pop only ever sees stored entries.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/timer_cmd_serializer.sv
// Serialises 4-bit delay commands as 1101+delay frames and handshakes done/ack.
// Optional command queue enabled by defining TIMER_CMD_FIFO_EN.
module timer_cmd_serializer
    import timer_pkg::*;
#(
    parameter int GAP_CYCLES      = 2,
    parameter int WATCHDOG_CYCLES = 20000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    timer_cmd_serializer_if.slave  cmd,
    output logic                   data,
    input  logic                   done,
    output logic                   ack,
    output logic                   busy,
    output logic                   cmd_done,
    output logic                   timeout_err
);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int WW = $clog2(WATCHDOG_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [WW-1:0] WD_LAST  = WW'(WATCHDOG_CYCLES - 1);
    localparam logic [2:0]    BIT_LAST = 3'(FRAME_BITS - 1);

    state_t                  state;
    logic [FRAME_BITS-1:0]   shreg;
    logic [GW-1:0]           gcnt;
    logic [2:0]              bcnt;
    logic [WW-1:0]           wd;
    logic                    take;
    logic [3:0]              take_delay;

`ifdef TIMER_CMD_FIFO_EN
    logic       fifo_full;
    logic       fifo_empty;
    logic [3:0] fifo_head;

    assign cmd.cmd_ready = !fifo_full;
    assign take          = (state == S_IDLE) && !fifo_empty;
    assign take_delay    = fifo_head;

    timer_cmd_fifo #(.DEPTH(4), .W(4)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (cmd.cmd_valid && !fifo_full),
        .din     (cmd.cmd_delay),
        .pop     (take),
        .dout    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );
`else
    assign cmd.cmd_ready = (state == S_IDLE);
    assign take          = cmd.cmd_valid && cmd.cmd_ready;
    assign take_delay    = cmd.cmd_delay;
`endif

    assign busy = (state != S_IDLE);

    // Frame sequencer: gap, shift-out, wait for done with watchdog, ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            shreg       <= '0;
            gcnt        <= '0;
            bcnt        <= '0;
            wd          <= '0;
            data        <= 1'b0;
            ack         <= 1'b0;
            cmd_done    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            data        <= 1'b0;
            ack         <= 1'b0;
            cmd_done    <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (take) begin
                        shreg <= frame_of(take_delay);
                        gcnt  <= '0;
                        state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gcnt == GAP_LAST) begin
                        gcnt  <= '0;
                        bcnt  <= '0;
                        state <= S_SHIFT;
                    end else begin
                        gcnt <= gcnt + GW'(1);
                    end
                end
                S_SHIFT: begin
                    data  <= shreg[FRAME_BITS-1];
                    shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
                    bcnt  <= bcnt + 3'd1;
                    if (bcnt == BIT_LAST) begin
                        wd    <= '0;
                        state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (done) begin
                        ack      <= 1'b1;
                        cmd_done <= 1'b1;
                        state    <= S_ACK;
                    end else if (wd == WD_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        wd <= wd + WW'(1);
                    end
                end
                S_ACK: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_timer_cmd_serializer.sv
// Bench for timer_cmd_serializer: timeline model of expected outputs per cycle.
// Also exercises the queue build when TIMER_CMD_FIFO_EN is defined.
module tb_timer_cmd_serializer;
    localparam int NC = 512;
    localparam int WD = 50;

    logic clk;
    logic reset_n;
    logic data, done, ack, busy, cmd_done, timeout_err;
    int   cyc = 0;
    int   errs = 0;
    int   checks = 0;
    bit   chk_en = 0;
    int   end_cyc = 300;

    bit       exp_data  [NC];
    bit       exp_busy  [NC];
    bit       exp_ack   [NC];
    bit       exp_to    [NC];
    bit       exp_ready [NC];
    bit       drv_valid [NC];
    bit       drv_done  [NC];
    bit [3:0] drv_delay [NC];
    bit       dut_data  [NC];
    bit       dut_busy  [NC];
    bit       dut_ack   [NC];
    bit       dut_to    [NC];
    bit       dut_rdy   [NC];

    timer_cmd_serializer_if ifc ();

    timer_cmd_serializer #(
        .GAP_CYCLES      (2),
        .WATCHDOG_CYCLES (WD)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cmd         (ifc),
        .data        (data),
        .done        (done),
        .ack         (ack),
        .busy        (busy),
        .cmd_done    (cmd_done),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Accept at first idle edge >= r; frame after a+3..a+10; done sampled at a+10+k.
    task automatic place(input int r, input logic [3:0] dl, input int k, output int a);
        logic [7:0] f;
        int t;
        f = {4'b1101, dl};
        a = r;
        while (exp_busy[a-1]) a++;
        for (int i = 0; i < 8; i++) exp_data[a+3+i] = f[7-i];
        if (k > 0) begin
            t = a + 10 + k;
            drv_done[t]   = 1'b1;
            drv_done[t+1] = 1'b1;
            exp_ack[t]    = 1'b1;
            for (int n = a; n <= t; n++) exp_busy[n] = 1'b1;
        end else begin
            t = a + 10 + WD;
            exp_to[t] = 1'b1;
            for (int n = a; n < t; n++) exp_busy[n] = 1'b1;
        end
    endtask

    task automatic req(input int r, input logic [3:0] dl, input int k, output int a);
        place(r, dl, k, a);
        for (int n = r; n <= a; n++) begin
            drv_valid[n] = 1'b1;
            drv_delay[n] = dl;
        end
    endtask

    function automatic logic [7:0] dframe(input int a);
        logic [7:0] f;
        for (int i = 0; i < 8; i++) f[7-i] = dut_data[a+3+i];
        return f;
    endfunction

    function automatic logic [7:0] mframe(input int a);
        logic [7:0] f;
        for (int i = 0; i < 8; i++) f[7-i] = exp_data[a+3+i];
        return f;
    endfunction

    // Input driver: values for the coming edge cyc+1.
    initial begin
        ifc.cmd_valid = 1'b0;
        ifc.cmd_delay = 4'h0;
        done = 1'b0;
        forever begin
            @(negedge clk);
            if (cyc + 1 < NC) begin
                ifc.cmd_valid = drv_valid[cyc+1];
                ifc.cmd_delay = drv_delay[cyc+1];
                done          = drv_done[cyc+1];
            end
        end
    end

    // Per-cycle comparison against the model timeline.
    always @(negedge clk) begin
        if (chk_en && cyc < NC) begin
            logic er;
`ifdef TIMER_CMD_FIFO_EN
            er = exp_ready[cyc];
`else
            er = !exp_busy[cyc];
`endif
            dut_data[cyc] = data;
            dut_busy[cyc] = busy;
            dut_ack[cyc]  = ack;
            dut_to[cyc]   = timeout_err;
            dut_rdy[cyc]  = ifc.cmd_ready;
            chk($sformatf("cyc%0d {data,busy,ack,cmd_done,to,ready}", cyc),
                {data, busy, ack, cmd_done, timeout_err, ifc.cmd_ready},
                {exp_data[cyc], exp_busy[cyc], exp_ack[cyc], exp_ack[cyc],
                 exp_to[cyc], er});
        end
    end

    int a1, a2, a3, a5, a6, a7, a8;
    int acks;

`ifdef TIMER_CMD_FIFO_EN
    int push_e [6] = '{10, 20, 21, 22, 23, 24};
    int acc_p  [6];
    int acc_a  [6];
    int nacc;
`endif

    initial begin
        reset_n = 1'b0;
`ifdef TIMER_CMD_FIFO_EN
        nacc = 0;
        for (int j = 0; j < 6; j++) begin
            int occ;
            occ = 0;
            for (int m = 0; m < nacc; m++) begin
                if (acc_p[m] < push_e[j]) occ++;
                if (acc_a[m] < push_e[j]) occ--;
            end
            drv_valid[push_e[j]] = 1'b1;
            drv_delay[push_e[j]] = 4'(j + 1);
            if (occ < 4) begin
                acc_p[nacc] = push_e[j];
                place(push_e[j] + 1, 4'(j + 1), 4, acc_a[nacc]);
                nacc++;
            end
        end
        for (int n = 0; n < NC; n++) begin
            int occ;
            occ = 0;
            for (int m = 0; m < nacc; m++) begin
                if (acc_p[m] <= n) occ++;
                if (acc_a[m] <= n) occ--;
            end
            exp_ready[n] = (occ < 4);
        end
        end_cyc = acc_a[nacc-1] + 30;
        chk("model_accepted_count", nacc, 5);
        chk("model_first_pop", acc_a[0], 11);
`else
        req(10, 4'h5, 30, a1);
        req(60, 4'hF, 3, a2);
        drv_done[a2+5] = 1'b1;
        req(62, 4'h0, WD, a3);
        drv_done[140] = 1'b1;
        req(150, 4'hA, 0, a5);
        req(215, 4'h3, 5, a6);
        req(240, 4'h9, 0, a7);
        chk("model_frame_5", mframe(a1), 8'hD5);
        chk("model_accept_b2b", a3, 75);
        chk("model_timeout_cycle", exp_to[a5+60], 1);
`endif
        @(negedge clk);
        chk("reset_outputs", {data, busy, ack, cmd_done, timeout_err}, 5'b0);
        chk("reset_ready", ifc.cmd_ready, 1'b1);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        chk_en  = 1'b1;
`ifndef TIMER_CMD_FIFO_EN
        wait (cyc == a7 + 6);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_clears", {data, busy, ack}, 3'b000);
        chk("bit3_before_reset", dut_data[a7+6], 1'b1);
        for (int n = a7 + 7; n < NC; n++) begin
            exp_data[n] = 0; exp_busy[n] = 0; exp_ack[n] = 0; exp_to[n] = 0;
            drv_valid[n] = 0; drv_done[n] = 0; drv_delay[n] = 0;
        end
        place(260, 4'h6, 2, a8);
        for (int n = 260; n <= a8; n++) begin
            drv_valid[n] = 1'b1;
            drv_delay[n] = 4'h6;
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
`endif
        wait (cyc == end_cyc);
        @(negedge clk);
        acks = 0;
        for (int n = 0; n < end_cyc; n++) acks += int'(dut_ack[n]);
`ifdef TIMER_CMD_FIFO_EN
        chk("fifo_fifth_not_ready", dut_rdy[23], 1'b0);
        chk("fifo_first_queued", dframe(acc_a[1]), 8'hD2);
        chk("fifo_last_queued", dframe(acc_a[4]), 8'hD5);
        chk("fifo_ack_count", acks, 5);
`else
        chk("frame_5", dframe(a1), 8'hD5);
        chk("gap_before_frame", {dut_data[a1+1], dut_data[a1+2]}, 2'b00);
        chk("ack_one_cycle", {dut_ack[a1+39], dut_ack[a1+40], dut_ack[a1+41]}, 3'b010);
        chk("busy_low_after_ack", dut_busy[a1+41], 1'b0);
        chk("frame_F", dframe(a2), 8'hDF);
        chk("frame_0_b2b", dframe(a3), 8'hD0);
        chk("tie_done_wins", {dut_ack[a3+60], dut_to[a3+60]}, 2'b10);
        chk("timeout_pulse", {dut_to[a5+59], dut_to[a5+60], dut_to[a5+61]}, 3'b010);
        chk("timeout_idle", dut_busy[a5+60], 1'b0);
        chk("after_timeout_frame", dframe(a6), 8'hD3);
        chk("fresh_frame_after_reset", dframe(a8), 8'hD6);
        chk("ack_count", acks, 5);
`endif
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
